multicycle_control_fsm: RTL



---
 rtl/multicycle_control_fsm.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control sequencer: shares one ALU and one memory port across states.
// Define ILLEGAL_TRAP_EN to park undefined opcodes in TRAP instead of retiring them as NOPs.
module multicycle_control_fsm #(
    parameter int IMMSRC_W  = 3,
    parameter int ALUOP_W   = 2,
    parameter int ZERO_WAIT = 0,
    parameter int CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                MemReq,
    output logic                MemWrite,
    output logic                AdrSrc,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                RegWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [IMMSRC_W-1:0] ImmSrc,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [3:0]          State,
    output logic [CNT_W-1:0]    InstrRetired,
    output logic                IllegalOp
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [IMMSRC_W-1:0] IMM_I = IMMSRC_W'(3'b000);
    localparam logic [IMMSRC_W-1:0] IMM_S = IMMSRC_W'(3'b001);
    localparam logic [IMMSRC_W-1:0] IMM_B = IMMSRC_W'(3'b010);
    localparam logic [IMMSRC_W-1:0] IMM_U = IMMSRC_W'(3'b100);

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(2'b10);

    state_t state;
    state_t next_state;
    logic   retire;
    logic   ready;

    // A zero-wait memory build treats every access as completing immediately.
    assign ready = MemReady | (ZERO_WAIT != 0);
    assign State = state;

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            S_FETCH:    if (ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BEQ:            next_state = S_BEQ;
                    OP_JAL:            next_state = S_JAL;
                    OP_LUI:            next_state = S_LUI;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        next_state = S_TRAP;
`else
                        next_state = S_FETCH;
                        retire     = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR:   next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (ready) next_state = S_MEMWB;
            S_MEMWB: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWRITE: if (ready) begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_EXECR, S_EXECI, S_JAL, S_LUI: next_state = S_ALUWB;
            S_ALUWB, S_BEQ: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            InstrRetired <= '0;
        end else begin
            state <= next_state;
            if (retire) InstrRetired <= InstrRetired + CNT_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                    IllegalOp <= 1'b0;
        else if (next_state == S_TRAP) IllegalOp <= 1'b1;
    end
`else
    assign IllegalOp = 1'b0;
`endif

    always_comb begin
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ImmSrc    = '0;
        ALUOp     = '0;
        case (state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready;
                PCWrite   = ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = IMM_B;
                ALUOp   = ALU_ADD;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = ALU_FUNC;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = IMM_I;
                ALUOp   = ALU_FUNC;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                ImmSrc  = IMM_U;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = ALU_SUB;
                PCWrite = Zero;
            end
            default: ;
        endcase
        // Reset abandons any access in flight, so strobes drop without waiting for the edge.
        if (!rst_n) begin
            MemReq   = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule
